// File: rtl/logic16_pkg.sv
// logic16_pkg: shared constants for the logic16 arbiter slice.
//   - opcode encodings for the shared 16-bit logic unit
//   - response-buffer state encoding
//   - datapath width
package logic16_pkg;

    localparam int W16 = 16;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;
    localparam logic [1:0] OP_NOT = 2'd3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/and16.sv
// and16: 16-bit bitwise AND gate.
//   i_a, i_b : operands
//   o_y      : i_a & i_b
module and16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_y
);
    assign o_y = i_a & i_b;
endmodule

// File: rtl/logic16_arbiter_rr_arb.sv
// rr_arb: combinational round-robin winner selection.
//   i_req   : request vector, one bit per requester
//   i_ptr   : highest-priority index
//   o_grant : one-hot grant of the winner (zero when no request)
//   o_idx   : winner index (0 when no request)
//   o_any   : at least one request is present
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);
    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_pos;

    // Scan from the lowest priority offset up to the pointer itself, so the
    // last hit recorded is the first requester at or after ptr.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        w_sum = '0;
        w_pos = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (IDW+1)'(k);
            if (w_sum >= NREQ_W) begin
                w_sum = w_sum - NREQ_W;
            end
            w_pos = w_sum[IDW-1:0];
            if (i_req[w_pos]) begin
                o_idx = w_pos;
                o_any = 1'b1;
            end
        end
    end

    always_comb begin
        o_grant = '0;
        if (o_any) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/not16.sv
// not16: 16-bit bitwise inverter.
//   i_a : operand
//   o_y : ~i_a
module not16 (
    input  logic [15:0] i_a,
    output logic [15:0] o_y
);
    assign o_y = ~i_a;
endmodule

// File: rtl/or16.sv
// or16: 16-bit bitwise OR gate.
//   i_a, i_b : operands
//   o_y      : i_a | i_b
module or16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_y
);
    assign o_y = i_a | i_b;
endmodule

// File: rtl/logic16_arbiter.sv
// logic16_arbiter: shares one 16-bit AND/OR/XOR/NOT unit between NREQ
// requesters with round-robin arbitration and a one-entry result buffer.
//   clk, rst_n           : clock, synchronous active-low reset
//   req_valid/req_ready  : per-requester handshake (req_ready one-hot or zero)
//   req_op/req_a/req_b   : packed per-requester opcode and operands
//   rsp_valid/rsp_ready  : result handshake
//   rsp_id, rsp_data     : requester index and result
//   rsp_zr, rsp_ng       : zero / negative flags, only with LOGIC16_ARB_FLAGS_EN
module logic16_arbiter
    import logic16_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [2*NREQ-1:0]   req_op,
    input  logic [W16*NREQ-1:0] req_a,
    input  logic [W16*NREQ-1:0] req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
`ifdef LOGIC16_ARB_FLAGS_EN
    output logic                rsp_zr,
    output logic                rsp_ng,
`endif
    output logic [W16-1:0]      rsp_data
);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

    state_t         r_state, w_state_next;
    logic [IDW-1:0] r_ptr, w_ptr_next;
    logic [IDW-1:0] r_id, w_id_next;
    logic [W16-1:0] r_data, w_data_next;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_win;
    logic            w_any;
    logic            w_can_accept;
    logic            w_accept;

    logic [1:0]     w_op_arr [NREQ];
    logic [W16-1:0] w_a_arr  [NREQ];
    logic [W16-1:0] w_b_arr  [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_op_arr[gi] = req_op[2*gi +: 2];
            assign w_a_arr[gi]  = req_a[W16*gi +: W16];
            assign w_b_arr[gi]  = req_b[W16*gi +: W16];
        end
    endgenerate

    rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_win),
        .o_any   (w_any)
    );

    // Logic unit built from the gate library; XOR = (a|b) & ~(a&b).
    logic [1:0]     w_op;
    logic [W16-1:0] w_a, w_b, w_and, w_or, w_nand, w_xor, w_not, w_result;

    assign w_op = w_op_arr[w_win];
    assign w_a  = w_a_arr[w_win];
    assign w_b  = w_b_arr[w_win];

    and16 u_and  (.i_a(w_a),  .i_b(w_b),    .o_y(w_and));
    or16  u_or   (.i_a(w_a),  .i_b(w_b),    .o_y(w_or));
    not16 u_nand (.i_a(w_and),              .o_y(w_nand));
    and16 u_xor  (.i_a(w_or), .i_b(w_nand), .o_y(w_xor));
    not16 u_not  (.i_a(w_a),                .o_y(w_not));

    always_comb begin
        case (w_op)
            OP_AND:  w_result = w_and;
            OP_OR:   w_result = w_or;
            OP_XOR:  w_result = w_xor;
            default: w_result = w_not;
        endcase
    end

    // A held result can be replaced in the same cycle it is consumed.
    assign w_can_accept = (r_state == ST_EMPTY) || rsp_ready;
    assign w_accept     = w_any && w_can_accept;
    assign req_ready    = (w_accept && rst_n) ? w_grant : '0;

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_id_next    = r_id;
        w_data_next  = r_data;
        if (w_accept) begin
            w_state_next = ST_FULL;
            w_data_next  = w_result;
            w_id_next    = w_win;
            w_ptr_next   = (w_win == LAST_IDX) ? '0 : w_win + 1'b1;
        end else if ((r_state == ST_FULL) && rsp_ready) begin
            w_state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_ptr   <= '0;
            r_id    <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_id    <= w_id_next;
            r_data  <= w_data_next;
        end
    end

    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_id    = r_id;
    assign rsp_data  = r_data;

`ifdef LOGIC16_ARB_FLAGS_EN
    logic r_zr, r_ng;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_zr <= 1'b1;
            r_ng <= 1'b0;
        end else if (w_accept) begin
            r_zr <= (w_result == '0);
            r_ng <= w_result[W16-1];
        end
    end

    assign rsp_zr = r_zr;
    assign rsp_ng = r_ng;
`endif

endmodule

// File: tb/tb_logic16_arbiter.sv
module tb_logic16_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
`ifdef LOGIC16_ARB_FLAGS_EN
    logic        rsp_zr;
    logic        rsp_ng;
`endif

    always #5 clk = ~clk;

    logic16_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
`ifdef LOGIC16_ARB_FLAGS_EN
        .rsp_zr    (rsp_zr),
        .rsp_ng    (rsp_ng),
`endif
        .rsp_data  (rsp_data)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int          m_ptr  = 0;
    bit          m_full = 1'b0;
    int          m_id   = 0;
    logic [15:0] m_data = 16'h0000;

    function automatic logic [15:0] ref_op(input int op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            0:       return a & b;
            1:       return a | b;
            2:       return a ^ b;
            default: return ~a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check the combinational grant, clock, then
    // update the model and check the registered outputs.
    task automatic step(input logic rst, input logic [3:0] v, input logic [7:0] op,
                        input logic [63:0] a, input logic [63:0] b, input logic rr);
        int          win;
        bit          acc;
        logic [3:0]  exp_ready;
        logic [15:0] res;
        rst_n     = rst;
        req_valid = v;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = rr;
        #1;
        win = -1;
        for (int k = 0; k < 4; k++) begin
            if (win < 0 && v[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
        end
        acc       = rst && (win >= 0) && (!m_full || rr);
        exp_ready = acc ? 4'(1 << win) : 4'b0000;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        if (!rst) begin
            m_full = 1'b0; m_id = 0; m_data = 16'h0000; m_ptr = 0;
        end else if (acc) begin
            res    = ref_op(int'(op[2*win +: 2]), a[16*win +: 16], b[16*win +: 16]);
            m_full = 1'b1; m_id = win; m_data = res; m_ptr = (win + 1) % 4;
        end else if (m_full && rr) begin
            m_full = 1'b0;
        end
        #1;
        check("rsp_valid", 32'(rsp_valid), 32'(m_full));
        check("rsp_id",    32'(rsp_id),    32'(m_id));
        check("rsp_data",  32'(rsp_data),  32'(m_data));
`ifdef LOGIC16_ARB_FLAGS_EN
        check("rsp_zr", 32'(rsp_zr), 32'(m_data == 16'h0000));
        check("rsp_ng", 32'(rsp_ng), 32'(m_data[15]));
`endif
        $display("t=%0t rst_n=%b valid=%b rr=%b ready=%b -> rsp_valid=%b id=%0d data=%h",
                 $time, rst, v, rr, exp_ready, rsp_valid, rsp_id, rsp_data);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        @(posedge clk); #1;

        // Reset: 3 cycles with every requester valid
        for (int i = 0; i < 3; i++) step(1'b0, 4'hF, 8'($urandom), rnd64(), rnd64(), 1'b1);

        // Single op: requester 2, OR AAAA | 5555
        step(1'b1, 4'b0100, 8'b00_01_00_00, {16'h0, 16'hAAAA, 32'h0}, {16'h0, 16'h5555, 32'h0}, 1'b1);
        check("single_id",   32'(rsp_id),   32'd2);
        check("single_data", 32'(rsp_data), 32'hFFFF);

        // Fairness from a fresh pointer
        step(1'b0, 4'h0, 8'h00, 64'h0, 64'h0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 4'hF, 8'($urandom), rnd64(), rnd64(), 1'b1);
            check("fair_id", 32'(rsp_id), 32'(i % 4));
        end

        // Backpressure: requester 0 AND 0000 & FFFF held, requester 1 waits
        step(1'b0, 4'h0, 8'h00, 64'h0, 64'h0, 1'b0);
        step(1'b1, 4'b0011, 8'b00_00_00_00, {32'h0, 16'h1234, 16'h0000}, {32'h0, 16'h00F0, 16'hFFFF}, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b0010, 8'h00, {32'h0, 16'h1234, 16'h0000}, {32'h0, 16'h00F0, 16'hFFFF}, 1'b0);
            check("bp_hold", 32'(rsp_data), 32'h0000);
        end
        step(1'b1, 4'b0010, 8'h00, {32'h0, 16'h1234, 16'h0000}, {32'h0, 16'h00F0, 16'hFFFF}, 1'b1);
        check("bp_next", 32'(rsp_data), 32'h0030);

        // NOT and XOR on requester 2 / 3
        step(1'b1, 4'b0100, 8'b00_11_00_00, {16'h0, 16'h00FF, 32'h0}, {16'h0, 16'h1111, 32'h0}, 1'b1);
        check("not_data", 32'(rsp_data), 32'hFF00);
        step(1'b1, 4'b1000, 8'b10_00_00_00, {16'hFFFF, 48'h0}, {16'hFFFF, 48'h0}, 1'b1);
        check("xor_data", 32'(rsp_data), 32'h0000);

        // Reset mid-operation
        step(1'b1, 4'b1000, 8'h00, rnd64(), rnd64(), 1'b0);
        step(1'b1, 4'b0000, 8'h00, rnd64(), rnd64(), 1'b0);
        step(1'b0, 4'hF, 8'h00, rnd64(), rnd64(), 1'b0);
        step(1'b1, 4'hF, 8'($urandom), rnd64(), rnd64(), 1'b1);
        check("rst_mid_id", 32'(rsp_id), 32'd0);

        // Random traffic, occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) != 0), 4'($urandom), 8'($urandom),
                 rnd64(), rnd64(), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
